gshare_predictor: RTL and testbench

Parametrised gshare direction predictor for the fetch stage of the MIPS core. It XOR-folds the fetch PC with a speculative global history register (GHR) to index a pattern history table (PHT) of saturating counters. It returns a same-cycle taken/not-taken prediction plus a history checkpoint. Resolved branches from decode train the PHT, and mispredicts restore the GHR. After every reset, a hardware init sweep loads the PHT before the predictor reports ready.

---
 rtl/gshare_predictor.sv | 116 +++++++++++
 tb/tb_gshare_predictor.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// gshare direction predictor: PC xor speculative GHR indexes a PHT of saturating counters.
// Latency: prediction is combinational (0 cycles); training and GHR recovery land on the next edge.
// Backpressure: none; accepts one lookup and one update every cycle once ready, ignores both during init.
module gshare_predictor #(
    parameter int ADDR_WIDTH  = 26,
    parameter int INDEX_WIDTH = 8,
    parameter int HIST_WIDTH  = 8,
    parameter int CTR_WIDTH   = 2,
    parameter int STAT_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    output logic                   ready,
    input  logic                   lookup_en,
    input  logic [ADDR_WIDTH-1:0]  lookup_pc,
    output logic                   pred_taken,
    output logic [INDEX_WIDTH-1:0] pred_index,
    output logic [HIST_WIDTH-1:0]  pred_hist,
    input  logic                   upd_valid,
    input  logic [INDEX_WIDTH-1:0] upd_index,
    input  logic [HIST_WIDTH-1:0]  upd_hist,
    input  logic                   upd_taken,
    input  logic                   upd_mispredict,
    output logic [STAT_WIDTH-1:0]  stat_branches,
    output logic [STAT_WIDTH-1:0]  stat_mispredicts
);

    localparam int PHT_DEPTH = 1 << INDEX_WIDTH;
    localparam logic [CTR_WIDTH-1:0] CTR_INIT = CTR_WIDTH'(1) << (CTR_WIDTH - 1);
    localparam logic [CTR_WIDTH-1:0] CTR_MAX  = '1;

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state, state_nxt;
    logic [INDEX_WIDTH-1:0] init_ptr;
    logic [HIST_WIDTH-1:0]  ghr;
    logic [CTR_WIDTH-1:0]   pht [0:PHT_DEPTH-1];
    logic                   run;
    logic [CTR_WIDTH-1:0]   upd_ctr;
    logic [CTR_WIDTH-1:0]   upd_ctr_nxt;
    logic                   recover;
    logic                   unused_pc_hi;

    assign unused_pc_hi = ^lookup_pc[ADDR_WIDTH-1:INDEX_WIDTH];

    assign run = (state == RUN);

    always_comb begin
        state_nxt = state;
        if (state == INIT && init_ptr == INDEX_WIDTH'(PHT_DEPTH - 1)) begin
            state_nxt = RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= INIT;
            init_ptr <= '0;
        end else begin
            state <= state_nxt;
            if (state == INIT) begin
                init_ptr <= init_ptr + 1'b1;
            end
        end
    end

    assign ready      = run;
    assign pred_index = lookup_pc[INDEX_WIDTH-1:0] ^ INDEX_WIDTH'(ghr);
    assign pred_taken = run & pht[pred_index][CTR_WIDTH-1];
    assign pred_hist  = ghr;

    assign upd_ctr = pht[upd_index];
    always_comb begin
        upd_ctr_nxt = upd_ctr;
        if (upd_taken) begin
            if (upd_ctr != CTR_MAX) upd_ctr_nxt = upd_ctr + 1'b1;
        end else begin
            if (upd_ctr != '0) upd_ctr_nxt = upd_ctr - 1'b1;
        end
    end

    // Single write port: the sweep owns it during INIT, training owns it in RUN.
    always_ff @(posedge clk) begin
        if (!run) begin
            pht[init_ptr] <= CTR_INIT;
        end else if (upd_valid) begin
            pht[upd_index] <= upd_ctr_nxt;
        end
    end

    assign recover = upd_valid & upd_mispredict;

    // Recovery from a resolved mispredict outranks the speculative shift of a concurrent lookup.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr <= '0;
        end else if (run) begin
            if (recover) begin
                ghr <= HIST_WIDTH'(upd_hist << 1) | HIST_WIDTH'(upd_taken);
            end else if (lookup_en) begin
                ghr <= HIST_WIDTH'(ghr << 1) | HIST_WIDTH'(pred_taken);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (run) begin
            if (upd_valid) stat_branches    <= stat_branches + 1'b1;
            if (recover)   stat_mispredicts <= stat_mispredicts + 1'b1;
        end
    end

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: expected predictions are queued by the stimulus and checked by a monitor.
module tb_gshare_predictor;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready;
    logic        lookup_en;
    logic [25:0] lookup_pc;
    logic        pred_taken;
    logic [7:0]  pred_index;
    logic [7:0]  pred_hist;
    logic        upd_valid;
    logic [7:0]  upd_index;
    logic [7:0]  upd_hist;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [31:0] stat_branches;
    logic [31:0] stat_mispredicts;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string      name;
        logic       taken;
        logic [7:0] index;
        logic [7:0] hist;
    } exp_t;
    exp_t exp_q[$];

    gshare_predictor dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ready            (ready),
        .lookup_en        (lookup_en),
        .lookup_pc        (lookup_pc),
        .pred_taken       (pred_taken),
        .pred_index       (pred_index),
        .pred_hist        (pred_hist),
        .upd_valid        (upd_valid),
        .upd_index        (upd_index),
        .upd_hist         (upd_hist),
        .upd_taken        (upd_taken),
        .upd_mispredict   (upd_mispredict),
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every lookup the DUT serves while ready is matched against the queued expectation.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && ready === 1'b1 && lookup_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_lookup: got index 0x%0h expected no lookup", pred_index);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk({e.name, "_taken"}, 32'(pred_taken), 32'(e.taken));
                chk({e.name, "_index"}, 32'(pred_index), 32'(e.index));
                chk({e.name, "_hist"},  32'(pred_hist),  32'(e.hist));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        lookup_en      = 1'b0;
        upd_valid      = 1'b0;
        upd_mispredict = 1'b0;
        upd_taken      = 1'b0;
        upd_index      = '0;
        upd_hist       = '0;
    endtask

    task automatic expect_lookup(input string name, input logic [25:0] pc,
                                 input logic t, input logic [7:0] idx, input logic [7:0] h);
        exp_t e;
        e.name  = name;
        e.taken = t;
        e.index = idx;
        e.hist  = h;
        exp_q.push_back(e);
        lookup_en = 1'b1;
        lookup_pc = pc;
    endtask

    task automatic train(input logic [7:0] idx, input logic taken, input int n);
        for (int i = 0; i < n; i++) begin
            upd_valid = 1'b1;
            upd_index = idx;
            upd_taken = taken;
            step();
        end
        upd_valid = 1'b0;
    endtask

    // Counts edges after release; ready must stay low for 255 and rise on the 256th.
    task automatic run_sweep(input string tag);
        for (int i = 1; i <= 256; i++) begin
            step();
            if (i == 1 || i == 255) chk({tag, "_ready_low"}, 32'(ready), 32'd0);
            if (i == 256)           chk({tag, "_ready_high"}, 32'(ready), 32'd1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        lookup_pc = 26'h3C;
        idle_inputs();
        #2;
        chk("rst_ready",      32'(ready),      32'd0);
        chk("rst_pred_taken", 32'(pred_taken), 32'd0);
        chk("rst_pred_index", 32'(pred_index), 32'h3C);
        chk("rst_pred_hist",  32'(pred_hist),  32'd0);
        chk("rst_stat_br",    stat_branches,    32'd0);
        chk("rst_stat_mis",   stat_mispredicts, 32'd0);
        repeat (3) step();
        rst_n = 1'b1;
        run_sweep("init");

        // Speculative shift from ghr=0, all counters weakly taken.
        expect_lookup("spec0", 26'h0, 1'b1, 8'h00, 8'h00); step();
        expect_lookup("spec1", 26'h0, 1'b1, 8'h01, 8'h01); step();
        expect_lookup("spec2", 26'h0, 1'b1, 8'h03, 8'h03); step();
        lookup_en = 1'b0;

        // Lookup and mispredict in one cycle: recovery wins, ghr -> 0x0A.
        expect_lookup("collide", 26'h10, 1'b1, 8'h17, 8'h07);
        upd_valid      = 1'b1;
        upd_mispredict = 1'b1;
        upd_index      = 8'h20;
        upd_hist       = 8'h05;
        upd_taken      = 1'b0;
        step();
        idle_inputs();
        expect_lookup("recovered", 26'h0, 1'b1, 8'h0A, 8'h0A); step();
        lookup_en = 1'b0;
        chk("collide_stat_br",  stat_branches,    32'd1);
        chk("collide_stat_mis", stat_mispredicts, 32'd1);

        // Saturation at index 5 (ghr now 0x15).
        train(8'h05, 1'b0, 3);
        expect_lookup("sat_low", 26'h10, 1'b0, 8'h05, 8'h15); step();
        lookup_en = 1'b0;
        train(8'h05, 1'b1, 4);
        expect_lookup("sat_high", 26'h2F, 1'b1, 8'h05, 8'h2A); step();
        lookup_en = 1'b0;
        chk("sat_stat_br", stat_branches, 32'd8);

        // No bypass at index 9 (ghr now 0x55).
        train(8'h09, 1'b0, 1);
        expect_lookup("nobypass_same", 26'h5C, 1'b0, 8'h09, 8'h55);
        upd_valid = 1'b1;
        upd_index = 8'h09;
        upd_taken = 1'b1;
        step();
        idle_inputs();
        expect_lookup("nobypass_next", 26'hA3, 1'b1, 8'h09, 8'hAA); step();
        lookup_en = 1'b0;
        chk("run_stat_br",  stat_branches,    32'd10);
        chk("run_stat_mis", stat_mispredicts, 32'd1);

        // Reset mid-RUN, then again 100 cycles into the sweep.
        rst_n = 1'b0;
        #1;
        chk("rerun_ready_async", 32'(ready),   32'd0);
        chk("rerun_stat_br",     stat_branches, 32'd0);
        step();
        rst_n = 1'b1;
        repeat (100) step();
        chk("midinit_ready", 32'(ready), 32'd0);
        rst_n = 1'b0;
        step();
        step();
        rst_n          = 1'b1;
        lookup_en      = 1'b1;
        lookup_pc      = 26'h20;
        upd_valid      = 1'b1;
        upd_mispredict = 1'b1;
        upd_hist       = 8'h7F;
        upd_taken      = 1'b1;
        #1;
        chk("init_pred_taken", 32'(pred_taken), 32'd0);
        for (int i = 1; i <= 256; i++) begin
            step();
            if (i == 255) begin
                chk("resweep_ready_low", 32'(ready), 32'd0);
                idle_inputs();
            end
            if (i == 256) chk("resweep_ready_high", 32'(ready), 32'd1);
        end
        chk("resweep_stat_br",  stat_branches,    32'd0);
        chk("resweep_stat_mis", stat_mispredicts, 32'd0);
        // Index 0x20 was trained to 01 before reset; the sweep restores weakly taken.
        expect_lookup("resweep_lookup", 26'h20, 1'b1, 8'h20, 8'h00); step();
        lookup_en = 1'b0;
        step();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
